ram_dp_be: RTL and testbench
============================

Name: ram_dp_be

Overview:
Parametrised dual-port synchronous RAM for the core. It is the successor of the single-port 32-bit/64 KB RAM.
- Port I: read-only instruction fetch.
- Port D: read/write data access with byte enables.
- Both ports use a valid/ready request handshake and a valid-qualified response.
- Provides power-on zero clear, alignment/range error reporting and a defined same-cycle collision rule.

Parameters:
DATA_W, 32, word width in bits; multiple of 8.
ADDR_W, 16, byte-address width on both ports.
DEPTH, 16384, number of words; DEPTH*DATA_W/8 must be <= 2^ADDR_W.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
i_req_valid  in  1  instruction read request.
i_req_ready  out  1  port I accepts a request this cycle.
i_addr  in  ADDR_W  byte address.
i_rsp_valid  out  1  i_rsp_data / i_rsp_err valid.
i_rsp_data  out  DATA_W  read word.
i_rsp_err  out  1  misaligned or out-of-range request.
d_req_valid  in  1  data request.
d_req_ready  out  1  port D accepts a request this cycle.
d_we  in  1  1 = write, 0 = read.
d_be  in  DATA_W/8  byte write enables; bit k covers bits [8k+7:8k].
d_addr  in  ADDR_W  byte address.
d_wdata  in  DATA_W  write data.
d_rsp_valid  out  1  d_rsp_data / d_rsp_err valid; also pulses for writes.
d_rsp_data  out  DATA_W  read word; 0 for writes.
d_rsp_err  out  1  misaligned or out-of-range request.

Behaviour:
- Word index = addr >> log2(DATA_W/8).
- Misaligned: any of the low log2(DATA_W/8) address bits nonzero.
- Out of range: word index >= DEPTH.
- Reset (reset_n low, asynchronous):
  - All *_rsp_valid, *_rsp_err, *_rsp_data = 0.
  - *_req_ready = 0.
  - FSM forced to INIT; clear counter = 0.
- FSM:
  - INIT: writes 0 to word[cnt] each cycle, cnt++; *_req_ready = 0. Requests presented in INIT are ignored, not queued.
  - When cnt == DEPTH-1 is written, go to RUN next cycle. INIT therefore lasts exactly DEPTH cycles after reset release.
  - RUN: i_req_ready = d_req_ready = 1 permanently.
- Handshake: a request is accepted when valid && ready at a rising edge. No backpressure on responses; the consumer must always take them.
- Latency: response is registered 1 cycle after acceptance; *_rsp_valid is high for exactly that one cycle. A request accepted every cycle gives a response every cycle.
- D write: each byte k with d_be[k] = 1 is updated. d_be = 0 is a legal no-op that still responds (valid = 1, err = 0).
- Errors: an erroneous request performs no memory access and responds with data = 0, err = 1.
- Collision, D write and I read of the same word in one cycle: I returns the pre-write contents (read-before-write). The write takes effect for any later request.
- D read never overlaps a D write (one op per port per cycle).
- Reset mid-operation:
  - Any in-flight response is dropped (rsp_valid forced to 0).
  - Memory is re-cleared through a full INIT.
- Out-of-range addresses never wrap onto valid words.

Optional Feature:
RAM_OUTREG_EN.
- Defined: adds a second output register stage on both ports. Read latency becomes 2 cycles; throughput is unchanged at 1 per cycle. Collision and error rules are identical, with the response delayed one further cycle. Reset clears both stages.
- Undefined: 1-cycle latency as above.

Test Plan:
1. Reset release, DEPTH=16 → req_ready low for exactly 16 cycles, then high; reading all 16 words returns 0x00000000 with err = 0.
2. Back-to-back D writes of random words to addr 0,4,...,60, then back-to-back D reads → d_rsp_valid high every cycle with 1-cycle lag; each word matches.
3. Byte-enable merge:
   - Write 0x11223344 to addr 8 with d_be = 4'b1111.
   - Then write 0xAABBCCDD with d_be = 4'b0101.
   - Read addr 8 → 0x11BB33DD.
4. Collision: word 3 holds 0xDEADBEEF; same cycle D writes 0x01234567 to addr 12 and I reads addr 12 → i_rsp_data = 0xDEADBEEF; next I read → 0x01234567.
5. Errors:
   - D write at addr 6 → d_rsp_err = 1, data 0, memory unchanged.
   - I read at addr 64 (DEPTH=16) → i_rsp_err = 1, i_rsp_data = 0; word 0 is unaffected.
6. Reset asserted the cycle after a D read is accepted → no d_rsp_valid pulse; INIT reruns; the previously written word reads 0. With RAM_OUTREG_EN, repeat scenario 2 and check 2-cycle latency.

Source files
------------

// File: rtl/ram_dp_be.sv
// Dual-port RAM: port I read-only fetch, port D read/write with byte enables; zero-cleared by an INIT sweep.
// Define RAM_OUTREG_EN to add a second response register stage (2-cycle latency) on both ports.
module ram_dp_be #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 16384
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_rsp_valid,
    output logic [DATA_W-1:0]     i_rsp_data,
    output logic                  i_rsp_err,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_rsp_valid,
    output logic [DATA_W-1:0]     d_rsp_data,
    output logic                  d_rsp_err
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(BYTES);
    localparam int unsigned MEM_AW = $clog2(DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    logic [MEM_AW-1:0] cnt;
    logic              ready;

    logic [ADDR_W-1:0] i_word;
    logic [ADDR_W-1:0] d_word;
    logic              i_ok;
    logic              d_ok;
    logic              i_acc;
    logic              d_acc;
    logic              d_wr_en;
    logic [MEM_AW-1:0] i_idx;
    logic [MEM_AW-1:0] d_idx;

    rsp_t              i_s1;
    rsp_t              d_s1;

    // Address decode: word index, alignment and range; out-of-range never aliases a valid word
    assign i_word  = i_addr >> OFF_W;
    assign d_word  = d_addr >> OFF_W;
    assign i_ok    = ((i_addr & ADDR_W'(BYTES - 1)) == '0) && (64'(i_word) < 64'(DEPTH));
    assign d_ok    = ((d_addr & ADDR_W'(BYTES - 1)) == '0) && (64'(d_word) < 64'(DEPTH));
    assign i_idx   = i_word[MEM_AW-1:0];
    assign d_idx   = d_word[MEM_AW-1:0];
    assign i_acc   = i_req_valid && ready;
    assign d_acc   = d_req_valid && ready;
    assign d_wr_en = d_acc && d_we && d_ok;

    assign i_req_ready = ready;
    assign d_req_ready = ready;

    // Clear sequencer: one word per cycle, RUN after the last word is written
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + MEM_AW'(1);
                    if (cnt == MEM_AW'(DEPTH - 1)) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; INIT and D writes are mutually exclusive because ready is low in INIT
    always_ff @(posedge clock) begin
        if (state == ST_INIT) begin
            mem[cnt] <= '0;
        end else if (d_wr_en) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                if (d_be[k]) begin
                    mem[d_idx][8*k +: 8] <= d_wdata[8*k +: 8];
                end
            end
        end
    end

    // First response stage; reads sample the pre-write array contents (read-before-write)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_s1 <= '0;
            d_s1 <= '0;
        end else begin
            i_s1.valid <= i_acc;
            i_s1.err   <= i_acc && !i_ok;
            i_s1.data  <= (i_acc && i_ok) ? mem[i_idx] : '0;
            d_s1.valid <= d_acc;
            d_s1.err   <= d_acc && !d_ok;
            d_s1.data  <= (d_acc && d_ok && !d_we) ? mem[d_idx] : '0;
        end
    end

`ifdef RAM_OUTREG_EN
    rsp_t i_s2;
    rsp_t d_s2;

    // Optional second output stage
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_s2 <= '0;
            d_s2 <= '0;
        end else begin
            i_s2 <= i_s1;
            d_s2 <= d_s1;
        end
    end

    assign i_rsp_valid = i_s2.valid;
    assign i_rsp_err   = i_s2.err;
    assign i_rsp_data  = i_s2.data;
    assign d_rsp_valid = d_s2.valid;
    assign d_rsp_err   = d_s2.err;
    assign d_rsp_data  = d_s2.data;
`else
    assign i_rsp_valid = i_s1.valid;
    assign i_rsp_err   = i_s1.err;
    assign i_rsp_data  = i_s1.data;
    assign d_rsp_valid = d_s1.valid;
    assign d_rsp_err   = d_s1.err;
    assign d_rsp_data  = d_s1.data;
`endif

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench for ram_dp_be with DEPTH=16; expected responses are queued at issue and checked by a monitor.
module tb_ram_dp_be;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 16;
`ifdef RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          i_req_ready;
    logic [AW-1:0] i_addr = '0;
    logic          i_rsp_valid;
    logic [DW-1:0] i_rsp_data;
    logic          i_rsp_err;
    logic          d_req_valid = 1'b0;
    logic          d_req_ready;
    logic          d_we = 1'b0;
    logic [3:0]    d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_rsp_valid;
    logic [DW-1:0] d_rsp_data;
    logic          d_rsp_err;

    always #5 clock = ~clock;

    ram_dp_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_req_valid (i_req_valid),
        .i_req_ready (i_req_ready),
        .i_addr      (i_addr),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_data  (i_rsp_data),
        .i_rsp_err   (i_rsp_err),
        .d_req_valid (d_req_valid),
        .d_req_ready (d_req_ready),
        .d_we        (d_we),
        .d_be        (d_be),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_data  (d_rsp_data),
        .d_rsp_err   (d_rsp_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        i_q[$];
    exp_t        d_q[$];
    exp_t        ie;
    exp_t        de;
    logic [31:0] model [DEPTH];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pop and compare whenever a response is presented
    always @(negedge clock) begin
        if (reset_n) begin
            if (i_rsp_valid) begin
                if (i_q.size() == 0) chk("i_unexpected_rsp", 32'd1, 32'd0);
                else begin
                    ie = i_q.pop_front();
                    chk("i_data", i_rsp_data, ie.data);
                    chk("i_err", 32'(i_rsp_err), 32'(ie.err));
                    chk("i_latency_cycle", 32'(cyc), 32'(ie.cyc));
                end
            end
            if (d_rsp_valid) begin
                if (d_q.size() == 0) chk("d_unexpected_rsp", 32'd1, 32'd0);
                else begin
                    de = d_q.pop_front();
                    chk("d_data", d_rsp_data, de.data);
                    chk("d_err", 32'(d_rsp_err), 32'(de.err));
                    chk("d_latency_cycle", 32'(cyc), 32'(de.cyc));
                end
            end
        end
    end

    function automatic logic bad(input logic [15:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 16'(DEPTH));
    endfunction

    task automatic tick();
        @(negedge clock);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        d_we        = 1'b0;
    endtask

    task automatic i_rd_x(input logic [15:0] a, input logic [31:0] x);
        exp_t e;
        i_req_valid = 1'b1;
        i_addr      = a;
        e.err  = bad(a);
        e.data = e.err ? 32'h0 : x;
        e.cyc  = cyc + LAT;
        i_q.push_back(e);
    endtask

    task automatic i_rd(input logic [15:0] a);
        i_rd_x(a, bad(a) ? 32'h0 : model[a[5:2]]);
    endtask

    task automatic d_rd_x(input logic [15:0] a, input logic [31:0] x);
        exp_t e;
        d_req_valid = 1'b1;
        d_we        = 1'b0;
        d_be        = 4'hF;
        d_addr      = a;
        e.err  = bad(a);
        e.data = e.err ? 32'h0 : x;
        e.cyc  = cyc + LAT;
        d_q.push_back(e);
    endtask

    task automatic d_rd(input logic [15:0] a);
        d_rd_x(a, bad(a) ? 32'h0 : model[a[5:2]]);
    endtask

    task automatic d_wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        d_req_valid = 1'b1;
        d_we        = 1'b1;
        d_be        = be;
        d_addr      = a;
        d_wdata     = wd;
        e.err  = bad(a);
        e.data = 32'h0;
        e.cyc  = cyc + LAT;
        if (!e.err)
            for (int k = 0; k < 4; k++)
                if (be[k]) model[a[5:2]][8*k +: 8] = wd[8*k +: 8];
        d_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((i_q.size() != 0 || d_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_i_pending", 32'(i_q.size()), 32'd0);
        chk("drain_d_pending", 32'(d_q.size()), 32'd0);
    endtask

    // Release reset and measure how many sampled cycles ready stays low
    task automatic release_and_init(input string name);
        int n;
        reset_n = 1'b1;
        n = 0;
        while (!i_req_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk(name, 32'(n), 32'(DEPTH));
        chk({name, "_d_ready"}, 32'(d_req_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d expected < 100000", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
        repeat (3) @(negedge clock);

        // Reset state
        chk("rst_i_outputs", {31'h0, i_rsp_valid} | 32'(i_rsp_err) | i_rsp_data, 32'h0);
        chk("rst_d_outputs", {31'h0, d_rsp_valid} | 32'(d_rsp_err) | d_rsp_data, 32'h0);
        chk("rst_ready", {30'h0, i_req_ready, d_req_ready}, 32'h0);

        // 1: INIT length and zeroed contents
        release_and_init("init_len");
        for (int i = 0; i < int'(DEPTH); i++) begin
            i_rd(16'(i * 4));
            tick();
        end
        drain();

        // 2: back-to-back D writes then D reads
        for (int i = 0; i < int'(DEPTH); i++) begin
            d_wr(16'(i * 4), 4'hF, $urandom | 32'h1);
            tick();
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            d_rd(16'(i * 4));
            tick();
        end
        drain();

        // 3: byte-enable merge
        d_wr(16'd8, 4'b1111, 32'h11223344);
        tick();
        d_wr(16'd8, 4'b0101, 32'hAABBCCDD);
        tick();
        d_rd_x(16'd8, 32'h11BB33DD);
        tick();

        // 4: same-cycle collision, read-before-write
        d_wr(16'd12, 4'hF, 32'hDEADBEEF);
        tick();
        i_rd_x(16'd12, 32'hDEADBEEF);
        d_wr(16'd12, 4'hF, 32'h01234567);
        tick();
        i_rd_x(16'd12, 32'h01234567);
        tick();
        drain();

        // 5: error handling and no-op byte enable
        d_wr(16'd6, 4'hF, 32'hFFFFFFFF);
        tick();
        d_rd(16'd4);
        i_rd(16'd64);
        tick();
        d_rd(16'd0);
        i_rd(16'd2);
        tick();
        d_rd(16'hFFFC);
        i_rd(16'd0);
        tick();
        d_wr(16'h0040, 4'hF, 32'hCAFEF00D);
        tick();
        d_wr(16'd16, 4'b0000, 32'hFFFFFFFF);
        tick();
        d_rd(16'd16);
        i_rd(16'd0);
        tick();
        d_rd_x(16'd8, 32'h11BB33DD);
        tick();
        drain();

        // 6: reset right after a D read is accepted drops the response and re-clears
        d_req_valid = 1'b1;
        d_we        = 1'b0;
        d_addr      = 16'd20;
        @(posedge clock);
        #1;
        reset_n     = 1'b0;
        d_req_valid = 1'b0;
        @(negedge clock);
        chk("rst_drop_d_valid", 32'(d_rsp_valid), 32'd0);
        chk("rst_ready_low", 32'(i_req_ready), 32'd0);
        tick();
        tick();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;
        release_and_init("reinit_len");
        d_rd(16'd20);
        i_rd(16'd20);
        tick();
        d_rd(16'd12);
        i_rd(16'd8);
        tick();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
